// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM sequencing instruction fetch, the ALU
// and the PC block. Owns the IR, the ZF/CF flag register and the sticky fault bit.
module pc_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic        alu_zf,
  input  logic        alu_cf,
  output logic        reg_we,
  output logic        zf,
  output logic        cf,
  output logic        pc_enable,
  output logic [2:0]  pc_jump_select,
  output logic [9:0]  pc_immediate,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_PC_CLR,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WAIT_ALU,
    S_UPDATE,
    S_HALT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_live;
  logic [15:0]     r_ir;
  logic [CW-1:0]   r_cnt;
  logic            r_zf;
  logic            r_cf;
  logic            r_fault;
  logic [9:0]      r_imm;

  logic            w_fault_set;
  logic            w_ir_load;
  logic            w_flag_load;
  logic            w_cnt_inc;
  logic            w_cnt_clr;
  logic [3:0]      w_opc;
  logic [2:0]      w_jsel_op;

  assign w_opc        = r_ir[15:12];
  assign alu_op       = r_ir[11:9];
  assign zf           = r_zf;
  assign cf           = r_cf;
  assign fault        = r_fault;
  assign pc_immediate = r_imm;

  // PC mode selected by the current opcode during UPDATE
  always_comb begin
    w_jsel_op = 3'b111;
    case (w_opc)
      4'h3:    w_jsel_op = 3'b001;
      4'h4:    w_jsel_op = 3'b010;
      4'h5:    w_jsel_op = 3'b011;
      4'h6:    w_jsel_op = 3'b100;
      4'h7:    w_jsel_op = 3'b101;
      4'h8:    w_jsel_op = 3'b110;
      4'h9:    w_jsel_op = 3'b000;
      default: w_jsel_op = 3'b111;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    w_next         = r_state;
    imem_req       = 1'b0;
    alu_start      = 1'b0;
    reg_we         = 1'b0;
    pc_enable      = 1'b0;
    pc_jump_select = 3'b111;
    halted         = 1'b0;
    w_fault_set    = 1'b0;
    w_ir_load      = 1'b0;
    w_flag_load    = 1'b0;
    w_cnt_inc      = 1'b0;
    w_cnt_clr      = 1'b0;
    case (r_state)
      // r_live holds the clear pulse off for the first cycle out of reset so
      // outputs keep their reset values while reset_n is asserted.
      S_PC_CLR: begin
        if (r_live) begin
          pc_enable      = 1'b1;
          pc_jump_select = 3'b000;
          w_next         = S_FETCH;
        end
      end
      // A non-zero count means req was already high, so it stays up even if run drops.
      S_FETCH: begin
        imem_req = run || (r_cnt != '0);
        if (imem_req) begin
          if (imem_ack) begin
            w_ir_load = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = S_DECODE;
          end else if (r_cnt == CW'(FETCH_TIMEOUT - 1)) begin
            w_fault_set = 1'b1;
            w_cnt_clr   = 1'b1;
            w_next      = S_HALT;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_DECODE: begin
        case (w_opc)
          4'h1, 4'h2:                      w_next = S_EXECUTE;
          4'hF:                            w_next = S_HALT;
          4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
            w_fault_set = 1'b1;
            w_next      = S_HALT;
          end
          default:                         w_next = S_UPDATE;
        endcase
      end
      S_EXECUTE: begin
        alu_start = 1'b1;
        w_next    = S_WAIT_ALU;
      end
      S_WAIT_ALU: begin
        if (alu_done) begin
          w_flag_load = 1'b1;
          reg_we      = (w_opc == 4'h1);
          w_next      = S_UPDATE;
        end
      end
      S_UPDATE: begin
        pc_enable      = 1'b1;
        pc_jump_select = w_jsel_op;
        w_next         = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_next = S_PC_CLR;
    endcase
  end

  // State, IR, flags, fetch counter, fault and immediate registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_PC_CLR;
      r_live  <= 1'b0;
      r_ir    <= '0;
      r_cnt   <= '0;
      r_zf    <= 1'b0;
      r_cf    <= 1'b0;
      r_fault <= 1'b0;
      r_imm   <= '0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_ir_load)   r_ir <= imem_data;
      if (w_cnt_clr)   r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      if (w_flag_load) begin
        r_zf <= alu_zf;
        r_cf <= alu_cf;
      end
      if (w_fault_set) r_fault <= 1'b1;
      if (w_next == S_UPDATE) r_imm <= r_ir[9:0];
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a
// per-instruction reference model (opcode table, latency formula, flag register).
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic        alu_zf = 1'b0;
  logic        alu_cf = 1'b0;
  logic        reg_we;
  logic        zf;
  logic        cf;
  logic        pc_enable;
  logic [2:0]  pc_jump_select;
  logic [9:0]  pc_immediate;
  logic        halted;
  logic        fault;

  int total = 0;
  int bad   = 0;
  logic mzf = 1'b0;
  logic mcf = 1'b0;

  pc_sequencer #(.FETCH_TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .alu_zf(alu_zf), .alu_cf(alu_cf), .reg_we(reg_we),
    .zf(zf), .cf(cf), .pc_enable(pc_enable), .pc_jump_select(pc_jump_select),
    .pc_immediate(pc_immediate), .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_jsel(input logic [3:0] op);
    case (op)
      4'h3: return 3'b001;
      4'h4: return 3'b010;
      4'h5: return 3'b011;
      4'h6: return 3'b100;
      4'h7: return 3'b101;
      4'h8: return 3'b110;
      4'h9: return 3'b000;
      default: return 3'b111;
    endcase
  endfunction

  // Reset, check reset values, release, expect the clear pulse before any fetch.
  task automatic startup();
    bit seen = 0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_pe",    pc_enable, 0);
    check("rst_jsel",  pc_jump_select, 3'b111);
    check("rst_imm",   pc_immediate, 0);
    check("rst_req",   imem_req, 0);
    check("rst_start", alu_start, 0);
    check("rst_we",    reg_we, 0);
    check("rst_aluop", alu_op, 0);
    check("rst_zf",    zf, 0);
    check("rst_cf",    cf, 0);
    check("rst_halt",  halted, 0);
    check("rst_fault", fault, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n  = 1'b1;
    alu_done = 1'b0;
    imem_ack = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clock);
      if (pc_enable) begin
        seen = 1;
        check("clr_jsel", pc_jump_select, 3'b000);
        check("clr_req",  imem_req, 0);
      end
    end
    check("clr_seen", seen, 1);
    mzf = 1'b0;
    mcf = 1'b0;
  endtask

  // One complete non-halting instruction with given ack wait, ALU wait and ALU flags.
  task automatic do_instr(input logic [15:0] ins, input int ackd, input int doned,
                          input logic azf, input logic acf, input bit drop);
    int cyc = 0, r0 = -1, p = -1, nreq = 0, nwe = 0, nst = 0, wc = 0;
    bit acked = 0, started = 0, dsent = 0, flag_bad = 0, req_bad = 0, op_bad = 0;
    logic [2:0] js = '0;
    logic [9:0] im = '0;
    logic fz = 1'b0, fc = 1'b0;
    logic [3:0] op = ins[15:12];
    bit isalu = (op == 4'h1) || (op == 4'h2);
    while (p < 0 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (!dsent && (zf !== mzf || cf !== mcf)) flag_bad = 1;
      if (r0 >= 0 && !acked && !imem_req) req_bad = 1;
      if (pc_enable) begin
        p  = cyc;
        js = pc_jump_select;
        im = pc_immediate;
        fz = zf;
        fc = cf;
      end
      imem_ack = 1'b0;
      alu_done = 1'b0;
      alu_zf   = 1'($urandom);
      alu_cf   = 1'($urandom);
      if (imem_req && !acked) begin
        if (r0 < 0) r0 = cyc;
        if (drop && nreq >= 1) run = 1'b0;
        if (nreq == ackd) begin
          imem_ack  = 1'b1;
          imem_data = ins;
          acked     = 1;
        end
        nreq++;
      end
      if (alu_start) begin
        nst++;
        started = 1;
        if (alu_op !== ins[11:9]) op_bad = 1;
      end else if (started && !dsent) begin
        if (alu_op !== ins[11:9]) op_bad = 1;
        if (wc == doned) begin
          alu_done = 1'b1;
          alu_zf   = azf;
          alu_cf   = acf;
          dsent    = 1;
        end
        wc++;
      end
      #1;
      if (reg_we) nwe++;
    end
    run      = 1'b1;
    imem_ack = 1'b0;
    alu_done = 1'b0;
    if (isalu) begin
      mzf = azf;
      mcf = acf;
    end
    check("ins_done",   p >= 0, 1);
    check("ins_jsel",   js, exp_jsel(op));
    check("ins_imm",    im, ins[9:0]);
    check("ins_regwe",  nwe, (op == 4'h1) ? 1 : 0);
    check("ins_start",  nst, isalu ? 1 : 0);
    check("ins_lat",    p - r0 + 1, ackd + (isalu ? doned + 5 : 3));
    check("ins_zf",     fz, mzf);
    check("ins_cf",     fc, mcf);
    check("ins_flhold", flag_bad, 0);
    check("ins_reqhold", req_bad, 0);
    check("ins_aluop",  op_bad, 0);
  endtask

  // Instruction expected to end in HALT; no PC update may be issued.
  task automatic halt_instr(input logic [15:0] ins, input logic exp_fault);
    int npe = 0;
    bit acked = 0, hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clock);
      if (pc_enable) npe++;
      if (halted) hit = 1;
      imem_ack = 1'b0;
      if (imem_req && !acked) begin
        imem_ack  = 1'b1;
        imem_data = ins;
        acked     = 1;
      end
    end
    imem_ack = 1'b0;
    check("hlt_seen",  hit, 1);
    check("hlt_fault", fault, exp_fault);
    check("hlt_pe",    npe, 0);
    check("hlt_req",   imem_req, 0);
  endtask

  initial begin
    int npe, nreq;
    bit hit;
    logic [15:0] ins;
    int ackd, doned;

    startup();

    // Paused: no request, and an ack while req is low must be ignored
    npe = 0; nreq = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (imem_req) nreq++;
      if (pc_enable) npe++;
      imem_ack  = 1'b1;
      imem_data = 16'h3000;
    end
    @(negedge clock);
    if (pc_enable) npe++;
    imem_ack = 1'b0;
    check("pause_req", nreq, 0);
    check("pause_pe",  npe, 0);
    run = 1'b1;

    // Three zero-wait NOPs
    for (int k = 0; k < 3; k++) do_instr(16'h0000, 0, 0, 1'b0, 1'b0, 0);
    // CMP then JE
    do_instr(16'h2000, 0, 3, 1'b1, 1'b0, 0);
    do_instr(16'h4005, 0, 0, 1'b0, 1'b0, 0);
    // ALU then JAE with negative offset
    do_instr(16'h1200, 0, 0, 1'b0, 1'b1, 0);
    do_instr(16'h73FE, 0, 0, 1'b0, 1'b0, 0);
    // Request held across a run drop
    do_instr(16'h3123, 3, 0, 1'b0, 1'b0, 1);

    // Randomized legal instruction stream
    for (int n = 0; n < 40; n++) begin
      ins   = {4'($urandom_range(0, 9)), 12'($urandom)};
      ackd  = $urandom_range(0, 5);
      doned = $urandom_range(0, 4);
      do_instr(ins, ackd, doned, 1'($urandom), 1'($urandom), (ackd >= 1) && ($urandom_range(0, 3) == 0));
    end

    // Reset while waiting on the ALU, with alu_done pending at reset
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clock);
      imem_ack = 1'b0;
      if (alu_start) hit = 1;
      else if (imem_req) begin
        imem_ack  = 1'b1;
        imem_data = 16'h1C00;
      end
    end
    imem_ack = 1'b0;
    check("t6_start", hit, 1);
    @(negedge clock);
    alu_done = 1'b1;
    alu_zf   = 1'b1;
    alu_cf   = 1'b1;
    startup();
    do_instr(16'h0000, 0, 0, 1'b0, 1'b0, 0);

    // Illegal opcode, then clean HALT
    halt_instr(16'hB000, 1'b1);
    startup();
    halt_instr(16'hF000, 1'b0);
    startup();

    // Fetch timeout: exactly 16 request cycles, then HALT with fault
    nreq = 0; hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clock);
      if (halted) hit = 1;
      else if (imem_req) nreq++;
    end
    check("t4_halt",  hit, 1);
    check("t4_nreq",  nreq, 16);
    check("t4_fault", fault, 1);
    check("t4_req",   imem_req, 0);
    npe = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (pc_enable || !halted) npe++;
      imem_ack  = 1'b1;
      imem_data = 16'h3000;
    end
    imem_ack = 1'b0;
    check("t4_late_ack", npe, 0);

    startup();
    do_instr(16'h1A00, 1, 2, 1'b1, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
